// File: rtl/cond_pkg.sv
// ---------------------------------------------------------------------------
// cond_pkg
// Shared definitions for the conditional-issue controller:
//   - 4-bit condition codes COND_EQ .. COND_NV
//   - bit positions of {z,c,n,v} inside the status register
//   - cond_pass(): evaluates a condition code against a flag set
// ---------------------------------------------------------------------------
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;  // z
    localparam logic [3:0] COND_NE = 4'b0001;  // ~z
    localparam logic [3:0] COND_CS = 4'b0010;  // c
    localparam logic [3:0] COND_CC = 4'b0011;  // ~c
    localparam logic [3:0] COND_MI = 4'b0100;  // n
    localparam logic [3:0] COND_PL = 4'b0101;  // ~n
    localparam logic [3:0] COND_VS = 4'b0110;  // v
    localparam logic [3:0] COND_VC = 4'b0111;  // ~v
    localparam logic [3:0] COND_HI = 4'b1000;  // c & ~z
    localparam logic [3:0] COND_LS = 4'b1001;  // ~c | z
    localparam logic [3:0] COND_GE = 4'b1010;  // n == v
    localparam logic [3:0] COND_LT = 4'b1011;  // n != v
    localparam logic [3:0] COND_GT = 4'b1100;  // ~z & (n == v)
    localparam logic [3:0] COND_LE = 4'b1101;  // z | (n != v)
    localparam logic [3:0] COND_AL = 4'b1110;  // always
    localparam logic [3:0] COND_NV = 4'b1111;  // never

    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic z;
        logic c;
        logic n;
        logic v;
        logic pass;
        z = flags[SR_Z];
        c = flags[SR_C];
        n = flags[SR_N];
        v = flags[SR_V];
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;          // COND_NV
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational condition evaluator.
// Ports:
//   cond  in  4  condition code
//   flags in  4  flag set {z,c,n,v}
//   pass  out 1  condition holds for the given flags
// ---------------------------------------------------------------------------
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    assign pass = cond_pass(cond, flags);

endmodule

// File: rtl/cond_issue_ctrl.sv
// ---------------------------------------------------------------------------
// cond_issue_ctrl
// Issue-stage controller for conditional execution. Owns the status register
// SR = {z,c,n,v}, evaluates each instruction's condition against it, tracks
// outstanding flag-setting instructions and stalls flag-dependent ones until
// their flags are written back.
//
// Optional build macro FLAG_FWD_EN: when the last outstanding writeback
// arrives in the same cycle a dependent instruction is offered, the
// instruction is accepted and evaluated on the incoming wb_flags.
//
// Ports:
//   clk, rst                      clock / asynchronous active-high reset
//   in_valid, in_ready            decode handshake
//   in_cond, in_set_flags, in_tag instruction fields
//   out_valid, out_ready          execute handshake
//   out_exec                      condition passed (0 = no-op)
//   out_set_flags, out_tag        registered instruction fields
//   wb_valid, wb_flags            flag writeback from execute
//   flush                         kills the output register
//   sr                            status register {z,c,n,v}
//   pend_cnt                      outstanding flag writes
//   wb_err                        sticky: writeback with nothing pending
// ---------------------------------------------------------------------------
module cond_issue_ctrl
    import cond_pkg::*;
#(
    parameter int MAX_PEND = 3,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic             in_set_flags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_exec,
    output logic             out_set_flags,
    output logic [TAG_W-1:0] out_tag,
    input  logic             wb_valid,
    input  logic [3:0]       wb_flags,
    input  logic             flush,
    output logic [3:0]       sr,
    output logic [2:0]       pend_cnt,
    output logic             wb_err
);

    logic             out_valid_q, out_valid_d;
    logic             out_exec_q, out_exec_d;
    logic             out_set_flags_q, out_set_flags_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [3:0]       sr_q, sr_d;
    logic [2:0]       pend_cnt_q, pend_cnt_d;
    logic             wb_err_q, wb_err_d;

    logic out_setter;   // output register holds an executing flag setter
    logic busy_flags;
    logic dep_raw;
    logic dep_stall;
    logic full_stall;
    logic cond_ok;
    logic accept;
    logic handoff;
    logic cnt_inc;
    logic cnt_dec;

    assign out_setter = out_valid_q & out_exec_q & out_set_flags_q;
    assign busy_flags = (pend_cnt_q != 3'd0) | out_setter;
    assign dep_raw    = ~((in_cond == COND_AL) | (in_cond == COND_NV)) & busy_flags;
    // The in-register setter counts toward the limit because it becomes
    // pending the moment it is handed off.
    assign full_stall = in_set_flags &
                        (({1'b0, pend_cnt_q} + {3'b000, out_setter}) >= 4'(MAX_PEND));

`ifdef FLAG_FWD_EN
    logic fwd_hit;
    logic pass_sr;
    logic pass_wb;

    // Last outstanding writeback arriving now with nothing else in flight:
    // the incoming flags are exactly what SR will hold next cycle.
    assign fwd_hit   = (pend_cnt_q == 3'd1) & ~out_setter & wb_valid;
    assign dep_stall = dep_raw & ~fwd_hit;

    cond_eval u_eval_sr (.cond(in_cond), .flags(sr_q),     .pass(pass_sr));
    cond_eval u_eval_wb (.cond(in_cond), .flags(wb_flags), .pass(pass_wb));

    assign cond_ok = fwd_hit ? pass_wb : pass_sr;
`else
    assign dep_stall = dep_raw;

    cond_eval u_eval (.cond(in_cond), .flags(sr_q), .pass(cond_ok));
`endif

    // Gating with rst keeps in_ready low while reset is held.
    assign in_ready = ~rst & (~out_valid_q | out_ready) & ~dep_stall & ~full_stall & ~flush;
    assign accept   = in_valid & in_ready;
    assign handoff  = out_valid_q & out_ready;
    assign cnt_inc  = handoff & out_exec_q & out_set_flags_q;
    assign cnt_dec  = wb_valid & (pend_cnt_q != 3'd0);

    always_comb begin
        out_valid_d     = out_valid_q;
        out_exec_d      = out_exec_q;
        out_set_flags_d = out_set_flags_q;
        out_tag_d       = out_tag_q;
        if (accept) begin
            out_valid_d     = 1'b1;
            out_exec_d      = cond_ok;
            out_set_flags_d = in_set_flags;
            out_tag_d       = in_tag;
        end else if (handoff | flush) begin
            // flush never coincides with accept since it blocks in_ready
            out_valid_d = 1'b0;
        end

        pend_cnt_d = pend_cnt_q + {2'b00, cnt_inc} - {2'b00, cnt_dec};
        sr_d       = cnt_dec ? wb_flags : sr_q;
        wb_err_d   = wb_err_q | (wb_valid & (pend_cnt_q == 3'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_exec_q      <= 1'b0;
            out_set_flags_q <= 1'b0;
            out_tag_q       <= '0;
            sr_q            <= 4'b0000;
            pend_cnt_q      <= 3'd0;
            wb_err_q        <= 1'b0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_exec_q      <= out_exec_d;
            out_set_flags_q <= out_set_flags_d;
            out_tag_q       <= out_tag_d;
            sr_q            <= sr_d;
            pend_cnt_q      <= pend_cnt_d;
            wb_err_q        <= wb_err_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_exec      = out_exec_q;
    assign out_set_flags = out_set_flags_q;
    assign out_tag       = out_tag_q;
    assign sr            = sr_q;
    assign pend_cnt      = pend_cnt_q;
    assign wb_err        = wb_err_q;

endmodule
